// File: rtl/input_capture.sv
// ----------------------------------------------------------------------------
// input_capture
//
// Front end of the user-input path. Synchronises the raw switch word and the
// raw active-low ENTER pushbutton, debounces ENTER, and on each accepted press
// while the control unit is stalled on an input instruction (REQ high) latches
// the switch word onto KEYS with a one-cycle VALID strobe.
//
// Ports
//   CLK      in   1           sole clock, rising edge
//   RST_N    in   1           asynchronous active-low reset
//   SW       in   KEYS_WIDTH  raw switches (asynchronous to CLK)
//   ENTER_N  in   1           raw pushbutton (asynchronous), 0 = pressed
//   REQ      in   1           high while an input instruction is stalled
//   KEYS     out  KEYS_WIDTH  last captured switch word, registered
//   VALID    out  1           one-cycle strobe, KEYS is new this cycle
//   WAITING  out  1           high while armed, drives "awaiting input" LED
//
// Parameters
//   KEYS_WIDTH       switch word width (sign + magnitude, not interpreted)
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept an ENTER change (>= 2)
//   CNT_WIDTH        debounce counter width, 2**CNT_WIDTH > DEBOUNCE_CYCLES
// ----------------------------------------------------------------------------
module input_capture #(
    parameter int KEYS_WIDTH      = 11,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [KEYS_WIDTH-1:0] SW,
    input  logic                  ENTER_N,
    input  logic                  REQ,
    output logic [KEYS_WIDTH-1:0] KEYS,
    output logic                  VALID,
    output logic                  WAITING
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        RELEASE
    } state_t;

    logic [KEYS_WIDTH-1:0] sw_meta;
    logic [KEYS_WIDTH-1:0] sw_sync;
    logic                  enter_meta;
    logic                  enter_sync;
    logic                  deb_n;
    logic [CNT_WIDTH-1:0]  deb_cnt;
    state_t                state;

    // ------------------------------------------------------------------------
    // Two-flop synchronisers. The switch word is only sampled once it has
    // been stable for two cycles, so per-bit synchronisation is sufficient.
    // ENTER resets to the released level so a held button after reset is
    // seen as a fresh press.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_meta    <= '0;
            sw_sync    <= '0;
            enter_meta <= 1'b1;
            enter_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each stage take the
            // previous stage's old value, giving a real two-flop chain.
            sw_meta    <= SW;
            sw_sync    <= sw_meta;
            enter_meta <= ENTER_N;
            enter_sync <= enter_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Debouncer: the counter measures how long the synced level has disagreed
    // with the debounced level. Any agreement clears it, so only an unbroken
    // run of DEBOUNCE_CYCLES disagreeing cycles moves deb_n.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            deb_n   <= 1'b1;
            deb_cnt <= '0;
        end else if (enter_sync == deb_n) begin
            deb_cnt <= '0;
        end else if (deb_cnt == CNT_LAST) begin
            deb_n   <= enter_sync;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + CNT_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Capture FSM with registered outputs. WAITING and VALID are set on the
    // edge that enters ARMED / CAPTURE, so they line up with the state.
    // IDLE only arms on a released button, so a press still held from the
    // previous instruction cannot satisfy the next one.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            KEYS    <= '0;
            VALID   <= 1'b0;
            WAITING <= 1'b0;
        end else begin
            // NOTE: default first, so VALID can only survive one cycle and
            // every path through the case leaves it defined.
            VALID <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (REQ && deb_n) begin
                        state   <= ARMED;
                        WAITING <= 1'b1;
                    end
                end
                ARMED: begin
                    // A withdrawn request wins over a simultaneous press.
                    if (!REQ) begin
                        state   <= IDLE;
                        WAITING <= 1'b0;
                    end else if (!deb_n) begin
                        state   <= CAPTURE;
                        WAITING <= 1'b0;
                        VALID   <= 1'b1;
                        KEYS    <= sw_sync;
                    end
                end
                CAPTURE: begin
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (deb_n) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    WAITING <= 1'b0;
                end
            endcase
        end
    end

endmodule
